// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer.
//   ERR_W / ERR_MAX : width and saturation value of the illegal-select counter
//   slot_state_e    : occupancy of a one-entry output slot
//   sel_width()     : select-index width for a given channel count (min 1)
package demux_pkg;

  localparam int unsigned ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry register slice holding a single beat for one output channel.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears state and data)
//   load       : write load_data into the slot this edge (caller loads only when free)
//   load_data  : payload to store
//   drain      : downstream accepts the held beat this cycle
//   valid      : slot is FULL
//   data       : held payload; keeps its last value while EMPTY
//   free       : slot can take a beat this cycle (EMPTY, or FULL and draining)
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             free
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      EMPTY: begin
        if (load) begin
          state_d = FULL;
          data_d  = load_data;
        end
      end
      FULL: begin
        // A load while draining replaces the beat in place, keeping the slot
        // FULL so a channel sustains one beat per cycle.
        if (load) begin
          data_d = load_data;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid = (state_q == FULL);
  assign data  = data_q;
  assign free  = (state_q == EMPTY) || drain;

endmodule

// File: rtl/demux_stream.sv
// Stream demultiplexer: routes each accepted upstream beat to one output
// channel (in_sel) or to all channels at once (in_bcast). Each channel has a
// one-entry slot, giving one-cycle latency and full per-channel throughput.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : upstream beat present
//   in_ready   : beat accepted when in_valid is also high (independent of in_valid)
//   in_data    : beat payload
//   in_sel     : destination channel index
//   in_bcast   : deliver to every channel, in_sel ignored
//   out_valid  : per-channel beat present
//   out_ready  : per-channel downstream accept
//   out_data   : channel k payload in bits [k*WIDTH +: WIDTH]
//   err_cnt    : saturating count of beats dropped for an illegal in_sel
module demux_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OUT = 4,
  localparam int unsigned SEL_W = sel_width(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bcast,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [ERR_W-1:0]       err_cnt
);

  logic [N_OUT-1:0] slot_free;
  logic [N_OUT-1:0] slot_load;
  logic [31:0]      sel_idx;
  logic             sel_legal;
  logic             sel_free;
  logic             accept;
  logic [ERR_W-1:0] err_q, err_d;

  assign sel_idx = 32'(in_sel);

  always_comb begin
    sel_legal = (sel_idx < N_OUT);

    // Loop-based select avoids indexing slot_free out of range when in_sel
    // encodes a channel that does not exist.
    sel_free = 1'b0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (sel_idx == k) begin
        sel_free = slot_free[k];
      end
    end

    if (rst) begin
      in_ready = 1'b0;
    end else if (in_bcast) begin
      in_ready = &slot_free;
    end else if (!sel_legal) begin
      in_ready = 1'b1;
    end else begin
      in_ready = sel_free;
    end

    accept = in_valid && in_ready;

    slot_load = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      slot_load[k] = accept && (in_bcast || (sel_idx == k));
    end

    err_d = err_q;
    if (accept && !in_bcast && !sel_legal && (err_q != ERR_MAX)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (slot_load[k]),
      .load_data(in_data),
      .drain    (out_ready[k]),
      .valid    (out_valid[k]),
      .data     (out_data[k*WIDTH +: WIDTH]),
      .free     (slot_free[k])
    );
  end

endmodule

// File: tb/tb_demux_stream.sv
// Scoreboard bench for demux_stream: per-channel expected-beat queues are fed
// by the stimulus tasks and drained by a negedge monitor on each handshake.
module tb_demux_stream;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           in_valid, in_ready, in_bcast;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic [N-1:0]   out_valid, out_ready;
  logic [N*W-1:0] out_data;
  logic [7:0]     err_cnt;

  logic            in3_valid, in3_ready, in3_bcast;
  logic [W-1:0]    in3_data;
  logic [1:0]      in3_sel;
  logic [N3-1:0]   out3_valid, out3_ready;
  logic [N3*W-1:0] out3_data;
  logic [7:0]      err3_cnt;

  demux_stream #(.WIDTH(W), .N_OUT(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_cnt(err_cnt)
  );

  demux_stream #(.WIDTH(W), .N_OUT(N3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in3_valid), .in_ready(in3_ready),
    .in_data(in3_data), .in_sel(in3_sel), .in_bcast(in3_bcast),
    .out_valid(out3_valid), .out_ready(out3_ready), .out_data(out3_data),
    .err_cnt(err3_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: beats waiting on each channel, last delivered value.
  logic [W-1:0] q[N][$];
  logic [W-1:0] last_d[N];
  int           err3_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: runs at negedge while inputs are stable for the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(q[k].size() != 0));
        if (q[k].size() != 0) begin
          check($sformatf("out_data[%0d]", k), 32'(out_data[k*W +: W]), 32'(q[k][0]));
          if (out_ready[k]) last_d[k] = q[k].pop_front();
        end else begin
          check($sformatf("hold_data[%0d]", k), 32'(out_data[k*W +: W]), 32'(last_d[k]));
        end
      end
      check("err_cnt", 32'(err_cnt), 32'd0);
    end
  end

  // One cycle of stimulus; in_ready is predicted from model occupancy after
  // the monitor has retired beats draining at the coming edge.
  task automatic beat(input bit v, input logic [1:0] sel, input logic [W-1:0] d,
                      input bit bc, input logic [N-1:0] rdy);
    bit exp_rdy;
    @(posedge clk); #1;
    in_valid = v; in_sel = sel; in_data = d; in_bcast = bc; out_ready = rdy;
    @(negedge clk); #1;
    if (bc) begin
      exp_rdy = 1'b1;
      for (int k = 0; k < N; k++) if (q[k].size() != 0) exp_rdy = 1'b0;
    end else begin
      exp_rdy = (q[sel].size() == 0);
    end
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (v && exp_rdy) begin
      if (bc) begin
        for (int k = 0; k < N; k++) q[k].push_back(d);
      end else begin
        q[sel].push_back(d);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b1; in_sel = 2'd0; in_bcast = 1'b0; in_data = 8'hEE; out_ready = '0;
    in3_valid = 1'b1; in3_sel = 2'd3; in3_bcast = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_in3_ready", 32'(in3_ready), 32'd0);
    for (int k = 0; k < N; k++) begin
      q[k].delete();
      last_d[k] = '0;
    end
    err3_exp = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0; in3_valid = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_err3_cnt", 32'(err3_cnt), 32'd0);
  endtask

  initial begin
    in_valid = 1'b0; in_sel = '0; in_data = '0; in_bcast = 1'b0; out_ready = '1;
    in3_valid = 1'b0; in3_sel = '0; in3_data = '0; in3_bcast = 1'b0; out3_ready = '1;
    for (int k = 0; k < N; k++) last_d[k] = '0;

    do_reset();

    // Single unicast to channel 2.
    beat(1, 2'd2, 8'hA5, 0, 4'b1111);
    beat(0, 2'd0, 8'h00, 0, 4'b1111);
    beat(0, 2'd0, 8'h00, 0, 4'b1111);

    // Stalled channel 1 back-pressures only itself.
    beat(1, 2'd1, 8'h11, 0, 4'b1101);
    beat(1, 2'd1, 8'h22, 0, 4'b1101);
    beat(1, 2'd3, 8'h33, 0, 4'b1101);
    beat(1, 2'd1, 8'h22, 0, 4'b1111);
    beat(0, 2'd0, 8'h00, 0, 4'b1111);

    // Broadcast waits for the stalled channel 2 to drain.
    beat(1, 2'd2, 8'h77, 0, 4'b1011);
    beat(1, 2'd0, 8'h3C, 1, 4'b1011);
    beat(1, 2'd0, 8'h3C, 1, 4'b1011);
    beat(1, 2'd0, 8'h3C, 1, 4'b1111);
    beat(0, 2'd0, 8'h00, 0, 4'b0000);
    beat(0, 2'd0, 8'h00, 0, 4'b1111);

    // Sustained one beat per cycle on channel 0.
    for (int i = 0; i < 16; i++) beat(1, 2'd0, 8'(i), 0, 4'b1111);
    beat(0, 2'd0, 8'h00, 0, 4'b1111);

    // Reset while channels 0 and 3 hold beats.
    beat(1, 2'd0, 8'hC0, 0, 4'b0000);
    beat(1, 2'd3, 8'hC3, 0, 4'b0000);
    do_reset();
    beat(0, 2'd0, 8'h00, 0, 4'b1111);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      beat($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom),
           $urandom_range(0, 7) == 0, 4'($urandom));
    end
    for (int i = 0; i < 4; i++) beat(0, 2'd0, 8'h00, 0, 4'b1111);

    // Illegal select on the three-channel instance saturates err_cnt.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      in3_valid = 1'b1; in3_sel = 2'd3; in3_bcast = 1'b0; in3_data = 8'(i);
      @(negedge clk); #1;
      check("ill_in_ready", 32'(in3_ready), 32'd1);
      check("ill_out_valid", 32'(out3_valid), 32'd0);
      check("ill_err_cnt", 32'(err3_cnt), 32'(err3_exp));
      if (err3_exp < 255) err3_exp++;
    end
    @(posedge clk); #1;
    in3_valid = 1'b0;
    check("ill_err_final", 32'(err3_cnt), 32'd255);
    check("ill_out_valid_final", 32'(out3_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter N_OUT, default 4, output channel count (legal range 2..16).
REQ-003 SHALL derive SEL_W = max(1, clog2(N_OUT)) as a localparam.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream beat present.
REQ-007 SHALL have port in_ready  output  1  beat accepted this cycle when in_valid is also high.
REQ-008 SHALL have port in_data  input  WIDTH  beat payload.
REQ-009 SHALL have port in_sel  input  SEL_W  destination channel index.
REQ-010 SHALL have port in_bcast  input  1  when high, beat goes to every channel and in_sel is ignored.
REQ-011 SHALL have port out_valid  output  N_OUT  per-channel beat present.
REQ-012 SHALL have port out_ready  input  N_OUT  per-channel downstream accept.
REQ-013 SHALL have port out_data  output  N_OUT*WIDTH  channel k payload in bits [k*WIDTH +: WIDTH].
REQ-014 SHALL have port err_cnt  output  8  saturating count of dropped beats with illegal in_sel.

Function
REQ-015 SHALL give each channel a one-entry slot, state EMPTY or FULL; out_valid[k] = (slot k FULL).
REQ-016 Slot k SHALL be "free" when EMPTY, or when FULL with out_ready[k] high in the same cycle.
REQ-017 Unicast (in_bcast=0, in_sel<N_OUT): in_ready = free(in_sel).
REQ-018 Broadcast (in_bcast=1): in_ready = AND of free(k) over all k; an accepted beat loads every slot in the same edge.
REQ-019 Illegal in_sel (>= N_OUT, in_bcast=0): in_ready=1; the beat is dropped; err_cnt increments by 1 and holds at 255.
REQ-020 Latency SHALL be 1 cycle: a beat accepted at edge n gives out_valid high with its payload after edge n.
REQ-021 Same-cycle drain and load of one slot SHALL leave it FULL with the new payload, giving 1 beat/cycle/channel sustained.
REQ-022 While out_valid[k]=1 and out_ready[k]=0, out_data[k] SHALL hold stable.
REQ-023 A slot draining with no load SHALL go EMPTY; out_data of an EMPTY slot SHALL hold its last value.
REQ-024 in_ready SHALL be combinational from in_valid-independent terms only (in_sel, in_bcast, slot state, out_ready); it SHALL NOT depend on in_valid.
REQ-025 A stalled channel SHALL NOT block unicast traffic to other channels.

Reset
REQ-026 While rst=1 at a clock edge: all slots SHALL go EMPTY, out_valid=0, out_data=0, and err_cnt=0.
REQ-027 in_ready SHALL be 0 in any cycle where rst=1; no beat is accepted or counted.
REQ-028 Reset asserted mid-transfer SHALL discard slot contents without any out_valid pulse.

Structure
REQ-029 Package demux_pkg SHALL hold ERR_W=8, ERR_MAX=255, and the slot-state enum {EMPTY, FULL}.
REQ-030 Sub-module demux_slot (one-entry register slice: load, drain, valid, data) SHALL be instantiated N_OUT times in a generate loop.
REQ-031 Select decode, broadcast AND-reduction, and err_cnt SHALL live in the top module.

Verification (WIDTH=8, N_OUT=4 unless stated)
REQ-032 Reset, then in_valid=1, in_sel=2, in_data=0xA5, all out_ready=1 -> next cycle out_valid=0100 and channel 2 data=0xA5; other out_valid bits stay 0.
REQ-033 out_ready[1]=0, two unicast beats to channel 1 (0x11, 0x22) -> first accepted, out_valid[1]=1 holding 0x11; in_ready=0 for the second beat; a beat to channel 3 is accepted meanwhile; raising out_ready[1] -> 0x22 is accepted in the same cycle.
REQ-034 Broadcast 0x3C with out_ready=1011 after a prior fill of channel 2 -> in_ready=0 until channel 2 drains; then all four channels show 0x3C after one edge.
REQ-035 N_OUT=3, in_sel=3 for 300 beats -> in_ready=1 every cycle, no out_valid, err_cnt reaches 255 and stays there.
REQ-036 Continuous beats to channel 0 with out_ready[0]=1 -> 1 beat/cycle, in-order data 0x00..0x0F.
REQ-037 Assert rst for one cycle while channels 0 and 3 are FULL -> next cycle out_valid=0000, err_cnt=0, in_ready=0 during the rst cycle.
